// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: the instruction word type, the
// fetch FSM states, the instruction size and the NOP flush value.
//   word_t        : 32-bit machine word
//   fetch_state_t : BOOT / RUN / HALT / FAULT
//   INS_BYTES     : PC increment per sequential fetch
//   NOP           : value loaded into id_ins when IF/ID is flushed
package cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int unsigned INS_BYTES = 4;
    localparam word_t       NOP       = 32'h0000_0000;

    // A target is misaligned when it is not on a word boundary.
    function automatic logic misaligned(input word_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bus bundle for the instruction-fetch stage.
//   Cache side    : ic_addr (word index), ic_ins (combinational return)
//   Control side  : redir_valid/redir_pc, halt_req
//   Decode side   : id_valid/id_ready handshake carrying id_pc/id_ins
//   Status        : fault, fault_pc, fetch_cnt
// master = fetch stage, slave = surrounding pipeline / cache.
interface if_fetch_stage_if #(
    parameter int ADDR_W = 7
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] ic_addr;
    word_t             ic_ins;
    logic              redir_valid;
    word_t             redir_pc;
    logic              halt_req;
    logic              id_valid;
    logic              id_ready;
    word_t             id_pc;
    word_t             id_ins;
    logic              fault;
    word_t             fault_pc;
    word_t             fetch_cnt;

    modport master (
        output ic_addr,
        input  ic_ins,
        input  redir_valid,
        input  redir_pc,
        input  halt_req,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_ins,
        output fault,
        output fault_pc,
        output fetch_cnt
    );

    modport slave (
        input  ic_addr,
        output ic_ins,
        output redir_valid,
        output redir_pc,
        output halt_req,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_ins,
        input  fault,
        input  fault_pc,
        input  fetch_cnt
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state selector for the fetch stage.
// Priority: redirect > halt > advance > hold.
//   Inputs : current state and pc, redirect request/target, halt level,
//            IF/ID valid and decode ready
//   Outputs: pc_next, state_next, load (capture ic_ins into IF/ID),
//            flush (invalidate IF/ID), set_fault (latch fault_pc),
//            drain (decode consumed IF/ID without a refill)
module pc_next_sel
    import cpu_pkg::*;
(
    input  fetch_state_t state,
    input  word_t        pc,
    input  logic         redir_valid,
    input  word_t        redir_pc,
    input  logic         halt_req,
    input  logic         id_valid,
    input  logic         id_ready,
    output word_t        pc_next,
    output fetch_state_t state_next,
    output logic         load,
    output logic         flush,
    output logic         set_fault,
    output logic         drain
);

    always_comb begin
        pc_next    = pc;
        state_next = state;
        load       = 1'b0;
        flush      = 1'b0;
        set_fault  = 1'b0;
        drain      = id_valid && id_ready;

        if (redir_valid) begin
            // Redirect ignores id_ready: any handoff this cycle still
            // completes, but the register is emptied afterwards.
            flush   = 1'b1;
            pc_next = redir_pc;
            if (misaligned(redir_pc)) begin
                set_fault  = 1'b1;
                state_next = FAULT;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                BOOT: state_next = RUN;
                RUN: begin
                    if (halt_req) begin
                        state_next = HALT;
                    end else if (!id_valid || id_ready) begin
                        load    = 1'b1;
                        pc_next = pc + word_t'(INS_BYTES);
                    end
                end
                default: ; // HALT and FAULT only leave via redirect
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the architectural PC, drives the cache
// word index, and captures the returned instruction into the IF/ID
// register under a valid/ready handshake toward decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : if_fetch_stage_if.master (cache, redirect, halt,
//                decode handshake, fault status, fetch counter)
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    ADDR_W   = 7
) (
    input logic                clk,
    input logic                rst_n,
    if_fetch_stage_if.master   bus
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    logic         load, flush, set_fault, drain;

    logic         id_valid;
    word_t        id_pc;
    word_t        id_ins;
    word_t        fault_pc;
    word_t        fetch_cnt;
    logic         fault;

    pc_next_sel u_sel (
        .state       (state),
        .pc          (pc),
        .redir_valid (bus.redir_valid),
        .redir_pc    (bus.redir_pc),
        .halt_req    (bus.halt_req),
        .id_valid    (id_valid),
        .id_ready    (bus.id_ready),
        .pc_next     (pc_next),
        .state_next  (state_next),
        .load        (load),
        .flush       (flush),
        .set_fault   (set_fault),
        .drain       (drain)
    );

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // IF/ID register, fault target and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid  <= 1'b0;
            id_pc     <= '0;
            id_ins    <= '0;
            fault_pc  <= '0;
            fetch_cnt <= '0;
        end else begin
            if (flush) begin
                id_valid <= 1'b0;
                id_ins   <= NOP;
            end else if (load) begin
                id_valid  <= 1'b1;
                id_pc     <= pc;
                id_ins    <= bus.ic_ins;
                fetch_cnt <= fetch_cnt + 32'd1;
            end else if (drain) begin
                id_valid <= 1'b0;
            end

            if (set_fault) begin
                fault_pc <= bus.redir_pc;
            end
        end
    end

    // Moore output: the fault flag is exactly the FAULT state.
    always_comb begin
        fault = (state == FAULT);
    end

    assign bus.ic_addr   = pc[ADDR_W+1:2];
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = id_pc;
    assign bus.id_ins    = id_ins;
    assign bus.fault     = fault;
    assign bus.fault_pc  = fault_pc;
    assign bus.fetch_cnt = fetch_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table applied one clock per
// entry, followed by hand-written asynchronous-reset and boot-redirect
// sequences. The cache returns 32'h1000_0000 + word index.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    localparam word_t B = 32'h1000_0000;

    typedef struct {
        logic       redir;
        word_t      rpc;
        logic       halt;
        logic       rdy;
        logic       e_valid;
        word_t      e_pc;
        word_t      e_ins;
        logic [6:0] e_addr;
        logic       e_fault;
        word_t      e_fpc;
        word_t      e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    vec_t vq[$];

    if_fetch_stage_if #(.ADDR_W(7)) bus ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.ic_ins = B + {25'd0, bus.ic_addr};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input word_t rp, input logic h, input logic rd,
                       input logic v, input word_t p, input word_t i, input logic [6:0] a,
                       input logic f, input word_t fp, input word_t c);
        vec_t t;
        t.redir = r;  t.rpc = rp;  t.halt = h;  t.rdy = rd;
        t.e_valid = v; t.e_pc = p; t.e_ins = i; t.e_addr = a;
        t.e_fault = f; t.e_fpc = fp; t.e_cnt = c;
        vq.push_back(t);
    endtask

    task automatic drive(input logic r, input word_t rp, input logic h, input logic rd);
        bus.redir_valid = r;
        bus.redir_pc    = rp;
        bus.halt_req    = h;
        bus.id_ready    = rd;
    endtask

    initial begin
        //   redir rpc           halt rdy | valid id_pc        id_ins    addr fault fpc    cnt
        add(0, 0,            0, 1,   0, 0,            0,        0,   0, 0,     0);  // BOOT idle
        add(0, 0,            0, 1,   1, 0,            B,        1,   0, 0,     1);
        add(0, 0,            0, 1,   1, 4,            B+1,      2,   0, 0,     2);
        add(0, 0,            0, 1,   1, 8,            B+2,      3,   0, 0,     3);
        add(0, 0,            0, 0,   1, 8,            B+2,      3,   0, 0,     3);  // stall x3
        add(0, 0,            0, 0,   1, 8,            B+2,      3,   0, 0,     3);
        add(0, 0,            0, 0,   1, 8,            B+2,      3,   0, 0,     3);
        add(0, 0,            0, 1,   1, 12,           B+3,      4,   0, 0,     4);
        add(1, 32'h40,       0, 0,   0, 0,            0,        16,  0, 0,     4);  // redirect, ready=0
        add(0, 0,            0, 0,   1, 32'h40,       B+16,     17,  0, 0,     5);
        add(1, 32'h42,       0, 0,   0, 0,            0,        16,  1, 32'h42, 5); // misaligned
        add(0, 0,            0, 1,   0, 0,            0,        16,  1, 32'h42, 5);
        add(0, 0,            0, 1,   0, 0,            0,        16,  1, 32'h42, 5);
        add(0, 0,            0, 1,   0, 0,            0,        16,  1, 32'h42, 5);
        add(0, 0,            0, 1,   0, 0,            0,        16,  1, 32'h42, 5);
        add(0, 0,            0, 1,   0, 0,            0,        16,  1, 32'h42, 5);
        add(1, 32'h80,       0, 1,   0, 0,            0,        32,  0, 0,     5);  // recover
        add(0, 0,            0, 1,   1, 32'h80,       B+32,     33,  0, 0,     6);
        add(1, 32'h14,       0, 1,   0, 0,            0,        5,   0, 0,     6);  // redirect+ready
        add(0, 0,            1, 1,   0, 0,            0,        5,   0, 0,     6);  // halt at pc=20
        add(0, 0,            1, 1,   0, 0,            0,        5,   0, 0,     6);
        add(0, 0,            0, 1,   0, 0,            0,        5,   0, 0,     6);  // halt dropped
        add(0, 0,            0, 1,   0, 0,            0,        5,   0, 0,     6);
        add(1, 32'h14,       0, 1,   0, 0,            0,        5,   0, 0,     6);  // resume
        add(0, 0,            0, 0,   1, 32'h14,       B+5,      6,   0, 0,     7);
        add(0, 0,            1, 0,   1, 32'h14,       B+5,      6,   0, 0,     7);  // halt, valid held
        add(0, 0,            1, 1,   0, 0,            0,        6,   0, 0,     7);  // drains in HALT
        add(1, 32'h100,      1, 1,   0, 0,            0,        64,  0, 0,     7);  // redirect+halt
        add(0, 0,            1, 1,   0, 0,            0,        64,  0, 0,     7);  // halt seen next
        add(1, 0,            0, 1,   0, 0,            0,        0,   0, 0,     7);
        add(0, 0,            0, 1,   1, 0,            B,        1,   0, 0,     8);
        add(1, 32'h200,      0, 1,   0, 0,            0,        0,   0, 0,     8);  // index wraps
        add(0, 0,            0, 1,   1, 32'h200,      B,        1,   0, 0,     9);
        add(1, 32'hFFFF_FFFC, 0, 1,  0, 0,            0,        127, 0, 0,     9);
        add(0, 0,            0, 0,   1, 32'hFFFF_FFFC, B+127,   0,   0, 0,     10); // pc wraps to 0
        add(0, 0,            0, 0,   1, 32'hFFFF_FFFC, B+127,   0,   0, 0,     10);

        rst_n = 1'b0;
        drive(0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, {31'd0, bus.id_valid}, 0);
        chk("rst_pc",    0, bus.id_pc, 0);
        chk("rst_ins",   0, bus.id_ins, 0);
        chk("rst_addr",  0, {25'd0, bus.ic_addr}, 0);
        chk("rst_fault", 0, {31'd0, bus.fault}, 0);
        chk("rst_fpc",   0, bus.fault_pc, 0);
        chk("rst_cnt",   0, bus.fetch_cnt, 0);
        rst_n = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].redir, vq[k].rpc, vq[k].halt, vq[k].rdy);
            @(posedge clk);
            #1;
            chk("valid", k, {31'd0, bus.id_valid}, {31'd0, vq[k].e_valid});
            chk("addr",  k, {25'd0, bus.ic_addr},  {25'd0, vq[k].e_addr});
            chk("fault", k, {31'd0, bus.fault},    {31'd0, vq[k].e_fault});
            chk("cnt",   k, bus.fetch_cnt, vq[k].e_cnt);
            if (vq[k].e_valid) begin
                chk("id_pc",  k, bus.id_pc,  vq[k].e_pc);
                chk("id_ins", k, bus.id_ins, vq[k].e_ins);
            end
            if (vq[k].e_fault) begin
                chk("fault_pc", k, bus.fault_pc, vq[k].e_fpc);
            end
        end

        // Asynchronous reset mid-stream with IF/ID valid.
        drive(0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("pre_async_valid", 0, {31'd0, bus.id_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 0, {31'd0, bus.id_valid}, 0);
        chk("async_cnt",   0, bus.fetch_cnt, 0);
        chk("async_addr",  0, {25'd0, bus.ic_addr}, 0);
        chk("async_fault", 0, {31'd0, bus.fault}, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("boot_valid", 0, {31'd0, bus.id_valid}, 0);
        chk("boot_addr",  0, {25'd0, bus.ic_addr}, 0);
        @(posedge clk);
        #1;
        chk("restart_valid", 0, {31'd0, bus.id_valid}, 1);
        chk("restart_pc",    0, bus.id_pc, 0);
        chk("restart_ins",   0, bus.id_ins, B);
        chk("restart_cnt",   0, bus.fetch_cnt, 1);

        // Redirect taken in the BOOT cycle.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(1, 32'h40, 0, 1);
        @(posedge clk);
        #1;
        chk("bootredir_valid", 0, {31'd0, bus.id_valid}, 0);
        chk("bootredir_addr",  0, {25'd0, bus.ic_addr}, 16);
        drive(0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("bootredir_pc",  0, bus.id_pc, 32'h40);
        chk("bootredir_cnt", 0, bus.fetch_cnt, 1);

        // Asynchronous reset clears a pending fault.
        drive(1, 32'h43, 0, 1);
        @(posedge clk);
        #1;
        chk("fault_set", 0, {31'd0, bus.fault}, 1);
        chk("fault_pc",  0, bus.fault_pc, 32'h43);
        drive(0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("fault_async",    0, {31'd0, bus.fault}, 0);
        chk("fault_pc_async", 0, bus.fault_pc, 0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction cache.
- Owns the architectural PC and drives the cache word index.
- Captures the returned instruction into the IF/ID pipeline register using a valid/ready handshake toward decode.
- Handles redirects from branches, jumps and exceptions, a halt request, and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
- ADDR_W, 7, instruction-cache index width in words (log2 of cache depth 128).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_addr  out  ADDR_W  cache word index, always equal to pc[ADDR_W+1:2].
- ic_ins  in  32  instruction returned combinationally by the cache for ic_addr.
- redir_valid  in  1  redirect request from EX/exception logic.
- redir_pc  in  32  redirect target byte address.
- halt_req  in  1  stop fetching (level).
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode accepts IF/ID contents this cycle.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_ins  out  32  instruction in IF/ID.
- fault  out  1  misaligned redirect target is pending.
- fault_pc  out  32  offending target address.
- fetch_cnt  out  32  count of instructions loaded into IF/ID.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - id_valid=0, id_pc=0, id_ins=0.
  - fault=0, fault_pc=0, fetch_cnt=0.
- ic_addr is purely combinational from pc. ic_ins is consumed in the same cycle.
- FSM states: BOOT, RUN, HALT, FAULT.
  - BOOT: lasts exactly one cycle after reset deassertion, with no fetch. Next state is RUN, unless redir_valid is high, in which case redirect rules apply.
  - RUN, advance condition `adv = !id_valid || id_ready`:
    - If adv: id_pc<=pc, id_ins<=ic_ins, id_valid<=1, pc<=pc+4, fetch_cnt++.
    - Else: pc and IF/ID hold.
    - PC addition wraps modulo 2^32. fetch_cnt wraps modulo 2^32.
  - RUN with halt_req=1 and no redirect: no new fetch. id_valid drains normally (clears on id_ready). Next state is HALT.
  - HALT: pc holds, no fetch. Exit only via redirect; halt_req deassertion alone does not resume.
  - FAULT: fault=1, fault_pc holds the target, id_valid=0, no fetch. Exit only via an aligned redirect.
- Redirect (redir_valid=1) has the highest priority in every state and ignores id_ready:
  - IF/ID is flushed: id_valid<=0 next cycle. The instruction fetched this cycle is discarded and fetch_cnt does not increment.
  - If redir_pc[1:0]==0: pc<=redir_pc, fault<=0, state<=RUN. The first fetch from the new pc occurs in the following cycle.
  - If redir_pc[1:0]!=0: pc<=redir_pc, fault_pc<=redir_pc, fault<=1, state<=FAULT.
- Simultaneous events:
  - redirect+halt_req: redirect wins and the state goes to RUN. halt_req still high is seen on the next cycle.
  - redirect+id_ready: the IF/ID handoff to decode completes this cycle (decode sees the old valid data); the register is then flushed.
- Reset asserted mid-operation immediately returns all outputs to their reset values, independent of clk.
- Throughput: one instruction per cycle while id_ready=1. Latency from pc to id_valid is one cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - word_t (logic [31:0]).
  - the fetch FSM enum {BOOT, RUN, HALT, FAULT}.
  - constant INS_BYTES=4.
  - the NOP encoding 32'h0000_0000, used as the id_ins flush value.
- One sub-module is natural: pc_next_sel, a combinational next-PC and next-state priority selector (redirect > halt > advance > hold). The PC register, FSM, IF/ID register and counter stay in if_fetch_stage.

Test Plan:
- Reset release with id_ready=1 and cache word i = 32'h1000_0000+i → one idle BOOT cycle, then id_pc=0,4,8,… with id_ins=32'h1000_0000,…_0001,… on consecutive cycles; fetch_cnt=3 after three fetches.
- Hold id_ready=0 for 3 cycles while id_valid=1 at id_pc=8 → id_pc/id_ins/pc stable; on id_ready=1, next id_pc=12 with no instruction skipped or duplicated.
- redir_valid=1, redir_pc=32'h40, with id_ready=0 → next cycle id_valid=0 and ic_addr=16; the following cycle id_pc=32'h40.
- redir_pc=32'h42 → fault=1, fault_pc=32'h42, id_valid stays 0 for 5 cycles; then redir_pc=32'h80 → fault=0 and the next id_pc=32'h80.
- halt_req=1 at pc=20 → no further fetch, state HALT, pc=20 held; dropping halt_req does not resume; redir_pc=20 resumes with id_pc=20.
- Assert rst_n=0 asynchronously mid-stream with id_valid=1 → id_valid, fault and fetch_cnt clear before the next clk edge; after release, fetch restarts at RESET_PC following one BOOT cycle.
